// File: rtl/i2c_tmp101_read_controller.sv
// i2c_tmp101_read_controller
//   Runs one two-byte I2C read of the TMP101 temperature register. The
//   TMP101 powers up pointing at the temperature register, so the
//   transaction is START, address+R, two data bytes (ACK then NACK), STOP.
//   Bit serialisation is done by an external 8-bit shift register. This
//   block only sequences its load/shift strobes and generates SCL/SDA
//   timing.
//
// Ports
//   CLOCK, Reset          system clock, asynchronous active-low reset
//   Start                 transaction request, sampled only in IDLE
//   Busy                  high from the cycle after Start is accepted until Done
//   Done                  one-cycle pulse when the transaction ends
//   AckError              slave did not ACK the address
//   Temperature           {MSB byte, LSB byte}, updated on a successful read
//   SCL                   push-pull bus clock, idles high
//   SDA_Drive             1 = pull SDA low, 0 = release
//   SDA_In                synchronised SDA pin level
//   WriteLoad/SentData    parallel load of {ADDR, R} into the shift register
//   ShiftorHold           shift the register by one bit this cycle
//   ShiftIn               serial input to the shift register
//   ShiftOut/ReceivedData shift register MSB and parallel contents

module i2c_tmp101_read_controller #(
    parameter int unsigned DIV  = 125,
    parameter logic [6:0]  ADDR = 7'b1001000
) (
    input  logic        CLOCK,
    input  logic        Reset,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        AckError,
    output logic [15:0] Temperature,
    output logic        SCL,
    output logic        SDA_Drive,
    input  logic        SDA_In,
    output logic        WriteLoad,
    output logic [7:0]  SentData,
    output logic        ShiftorHold,
    output logic        ShiftIn,
    input  logic        ShiftOut,
    input  logic [7:0]  ReceivedData
);

    localparam int unsigned   CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] QLAST = CW'(DIV - 1);

    // S_FINISH is a single wrap-up cycle after the STOP slot. It places
    // Done one cycle after the last quarter tick and keeps Busy high up to
    // that point.
    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_MSB,
        S_MACK,
        S_LSB,
        S_NACK,
        S_STOP,
        S_FINISH
    } state_t;

    state_t state;
    state_t nextState;

    logic [CW-1:0] quarterCnt;
    logic [1:0]    phase;       // quarter within the current bit slot
    logic [2:0]    bitCnt;      // bit within a byte state
    logic [7:0]    msbByte;

    logic inXfer;
    logic tick;
    logic slotEnd;
    logic lastBit;
    logic accept;

    // Counters only run while a bit slot is in progress. Holding them at
    // zero in IDLE also gives the clear on Start acceptance.
    assign inXfer  = (state != S_IDLE) && (state != S_FINISH);
    assign tick    = inXfer && (quarterCnt == QLAST);
    assign slotEnd = tick && (phase == 2'd3);
    assign lastBit = (bitCnt == 3'd7);
    // Start is not accepted during the Done cycle.
    assign accept  = (state == S_IDLE) && Start && !Done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------
    // Quarter, phase and bit counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            quarterCnt <= '0;
            phase      <= 2'd0;
            bitCnt     <= 3'd0;
        end else if (!inXfer) begin
            quarterCnt <= '0;
            phase      <= 2'd0;
            bitCnt     <= 3'd0;
        end else begin
            quarterCnt <= tick ? '0 : quarterCnt + 1'b1;
            if (tick) begin
                phase <= phase + 2'd1;
            end
            if (slotEnd) begin
                bitCnt <= (nextState != state) ? 3'd0 : bitCnt + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   if (accept)             nextState = S_START;
            S_START:  if (slotEnd)            nextState = S_ADDR;
            S_ADDR:   if (slotEnd && lastBit) nextState = S_AACK;
            // AckError was captured at the Q2 tick of this slot.
            S_AACK:   if (slotEnd)            nextState = AckError ? S_STOP : S_MSB;
            S_MSB:    if (slotEnd && lastBit) nextState = S_MACK;
            S_MACK:   if (slotEnd)            nextState = S_LSB;
            S_LSB:    if (slotEnd && lastBit) nextState = S_NACK;
            S_NACK:   if (slotEnd)            nextState = S_STOP;
            S_STOP:   if (slotEnd)            nextState = S_FINISH;
            S_FINISH:                         nextState = S_IDLE;
            default:                          nextState = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus pins and shift strobe
    // Within a data slot SCL is low for Q0/Q1 and high for Q2/Q3, which
    // is simply phase[1]. SDA only changes on slot entry while SCL is low.
    // The exceptions are the START and STOP slots.
    // ------------------------------------------------------------------
    always_comb begin
        SCL         = 1'b1;
        SDA_Drive   = 1'b0;
        ShiftorHold = 1'b0;
        case (state)
            S_START: begin
                SCL       = (phase != 2'd3);
                SDA_Drive = phase[1];               // SDA falls at Q2 with SCL high
            end
            S_ADDR: begin
                SCL         = phase[1];
                SDA_Drive   = ~ShiftOut;
                // Shifting on the slot's last tick presents the next bit
                // exactly at the following Q0 entry.
                ShiftorHold = slotEnd;
            end
            S_AACK, S_NACK: begin
                SCL = phase[1];
            end
            S_MSB, S_LSB: begin
                SCL         = phase[1];
                ShiftorHold = tick && (phase == 2'd2);
            end
            S_MACK: begin
                SCL       = phase[1];
                SDA_Drive = 1'b1;
            end
            S_STOP: begin
                SCL       = phase[1];
                SDA_Drive = (phase != 2'd3);        // SDA rises at Q3 with SCL high
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered handshake, status and result
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            Busy        <= 1'b0;
            Done        <= 1'b0;
            AckError    <= 1'b0;
            Temperature <= 16'h0000;
            WriteLoad   <= 1'b0;
            SentData    <= 8'h00;
            ShiftIn     <= 1'b0;
            msbByte     <= 8'h00;
        end else begin
            WriteLoad <= accept;
            Done      <= (state == S_FINISH);
            // SDA is stable for the whole SCL-high half. The one-cycle-old
            // copy is therefore valid when the Q2 shift strobe fires.
            ShiftIn   <= SDA_In;

            if (accept) begin
                Busy     <= 1'b1;
                AckError <= 1'b0;
                SentData <= {ADDR, 1'b1};
            end else if (state == S_FINISH) begin
                Busy <= 1'b0;
            end

            if ((state == S_AACK) && tick && (phase == 2'd2) && SDA_In) begin
                AckError <= 1'b1;
            end

            // The last MSB shift happened at the Q2 tick, a full quarter
            // before this transition, so ReceivedData already holds the byte.
            if ((state == S_MSB) && (nextState == S_MACK)) begin
                msbByte <= ReceivedData;
            end

            if ((state == S_FINISH) && !AckError) begin
                Temperature <= {msbByte, ReceivedData};
            end
        end
    end

endmodule

// File: tb/tb_i2c_tmp101_read_controller.sv
// Self-checking bench for i2c_tmp101_read_controller. Two instances run:
// DIV=4 (index 0) and DIV=2 (index 1). Each instance has a shift register
// model and a TMP101-like slave model. Expected results are queued when a
// transaction is launched and compared when Done fires.

module tb_i2c_tmp101_read_controller;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    logic [1:0]       start, busy, done, ackError, scl, sdaDrive, sdaIn;
    logic [1:0]       writeLoad, shiftorHold, shiftIn, shiftOut;
    logic [1:0][7:0]  sentData, receivedData;
    logic [1:0][15:0] temperature;
    logic [1:0][7:0]  sr = '0;
    logic [1:0]       slvDrv = '0;

    i2c_tmp101_read_controller #(.DIV(4), .ADDR(7'b1001000)) dut4 (
        .CLOCK(clk), .Reset(Reset), .Start(start[0]), .Busy(busy[0]), .Done(done[0]),
        .AckError(ackError[0]), .Temperature(temperature[0]), .SCL(scl[0]),
        .SDA_Drive(sdaDrive[0]), .SDA_In(sdaIn[0]), .WriteLoad(writeLoad[0]),
        .SentData(sentData[0]), .ShiftorHold(shiftorHold[0]), .ShiftIn(shiftIn[0]),
        .ShiftOut(shiftOut[0]), .ReceivedData(receivedData[0]));

    i2c_tmp101_read_controller #(.DIV(2), .ADDR(7'b1001000)) dut2 (
        .CLOCK(clk), .Reset(Reset), .Start(start[1]), .Busy(busy[1]), .Done(done[1]),
        .AckError(ackError[1]), .Temperature(temperature[1]), .SCL(scl[1]),
        .SDA_Drive(sdaDrive[1]), .SDA_In(sdaIn[1]), .WriteLoad(writeLoad[1]),
        .SentData(sentData[1]), .ShiftorHold(shiftorHold[1]), .ShiftIn(shiftIn[1]),
        .ShiftOut(shiftOut[1]), .ReceivedData(receivedData[1]));

    // Open-drain line: low if either the master or the slave pulls it.
    assign sdaIn        = ~(sdaDrive | slvDrv);
    assign shiftOut     = {sr[1][7], sr[0][7]};
    assign receivedData = sr;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (writeLoad[i])        sr[i] <= sentData[i];
            else if (shiftorHold[i]) sr[i] <= {sr[i][6:0], shiftIn[i]};
        end
    end

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Slave configuration and bus observations, one entry per instance.
    logic [7:0]  slvMsb [2];
    logic [7:0]  slvLsb [2];
    logic        slvNack[2];
    int          riseCnt[2], startCnt[2], stopCnt[2], doneCnt[2], startEdge[2];
    logic [7:0]  addr   [2];
    logic [31:0] riseSda[2];
    logic [1:0]  sclP = 2'b11, sdaP = 2'b11, busyP = 2'b00;

    typedef struct {
        int          inst;
        logic [15:0] temp;
        logic        ack;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    // Slave response after the falling SCL edge that follows rising edge r.
    // Rises 1..8 carry the address, 9 the ACK, 10..17 the MSB, 18 the MACK,
    // 19..26 the LSB and 27 the NACK.
    function automatic logic slvBit(input int r, input logic [7:0] m,
                                    input logic [7:0] l, input logic nack);
        if (r == 8) return !nack;
        if (nack) return 1'b0;
        if (r >= 9 && r <= 16) return !m[16 - r];
        if (r >= 18 && r <= 25) return !l[25 - r];
        return 1'b0;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            riseCnt[i] = 0; startCnt[i] = 0; stopCnt[i] = 0; doneCnt[i] = 0;
            startEdge[i] = 0; addr[i] = 8'h00; riseSda[i] = 32'h0;
            slvMsb[i] = 8'h00; slvLsb[i] = 8'h00; slvNack[i] = 1'b0;
        end
    end

    // Bus monitor, slave model and scoreboard checker.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic line;
        for (int i = 0; i < 2; i++) begin
            line = sdaIn[i];
            if (!Reset) begin
                slvDrv[i] = 1'b0;
            end else begin
                if (scl[i] && sclP[i] && sdaP[i] && !line) begin
                    startCnt[i]++;
                    riseCnt[i] = 0;
                    addr[i]    = 8'h00;
                    riseSda[i] = 32'h0;
                end
                if (scl[i] && sclP[i] && !sdaP[i] && line) stopCnt[i]++;
                if (scl[i] && !sclP[i]) begin
                    riseCnt[i]++;
                    if (riseCnt[i] < 32) riseSda[i][riseCnt[i]] = line;
                    if (riseCnt[i] <= 8) addr[i] = {addr[i][6:0], line};
                end
                if (!scl[i] && sclP[i])
                    slvDrv[i] = slvBit(riseCnt[i], slvMsb[i], slvLsb[i], slvNack[i]);
                if (busy[i] && !busyP[i]) startEdge[i] = cycle;
                if (done[i]) begin
                    doneCnt[i]++;
                    if (sbq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: got Done on inst %0d, expected none", i);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_inst", i, e.inst);
                        chk("sb_temperature", int'(temperature[i]), int'(e.temp));
                        chk("sb_ackerror", int'(ackError[i]), int'(e.ack));
                        chk("sb_done_latency", cycle - startEdge[i], e.cyc);
                        chk("sb_busy_clear", int'(busy[i]), 0);
                    end
                end
            end
            sclP[i]  = scl[i];
            sdaP[i]  = line;
            busyP[i] = busy[i];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input int i, input logic [7:0] m, input logic [7:0] l,
                          input logic nack, input bit doPush, input logic [15:0] eTemp,
                          input logic eAck, input int eCyc);
        slvMsb[i]  = m;
        slvLsb[i]  = l;
        slvNack[i] = nack;
        if (doPush) sbq.push_back('{i, eTemp, eAck, eCyc});
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
    endtask

    task automatic waitDone(input int i);
        for (int k = 0; k < 1500; k++) begin
            if (done[i]) return;
            step();
        end
        tests++;
        fails++;
        $display("FAIL done_timeout: got no Done on inst %0d, expected one", i);
    endtask

    task automatic waitRise(input int i, input int n);
        for (int k = 0; k < 1500; k++) begin
            if (riseCnt[i] >= n) return;
            step();
        end
        tests++;
        fails++;
        $display("FAIL rise_timeout: got %0d SCL rises, expected %0d", riseCnt[i], n);
    endtask

    task automatic runTxn(input int i, input logic [7:0] m, input logic [7:0] l,
                          input logic nack, input logic [15:0] eTemp,
                          input logic eAck, input int eCyc);
        int s0, p0, d0;
        s0 = startCnt[i];
        p0 = stopCnt[i];
        d0 = doneCnt[i];
        launch(i, m, l, nack, 1'b1, eTemp, eAck, eCyc);
        waitDone(i);
        repeat (2) step();
        chk("addr_bits", int'(addr[i]), 8'h91);
        chk("scl_rises", riseCnt[i], nack ? 10 : 28);
        chk("addr_ack_bit", int'(riseSda[i][9]), int'(nack));
        if (!nack) begin
            chk("master_ack_bit", int'(riseSda[i][18]), 0);
            chk("master_nack_bit", int'(riseSda[i][27]), 1);
        end
        chk("start_conditions", startCnt[i] - s0, 1);
        chk("stop_conditions", stopCnt[i] - p0, 1);
        chk("done_pulses", doneCnt[i] - d0, 1);
    endtask

    typedef struct {
        int          inst;
        logic [7:0]  msb;
        logic [7:0]  lsb;
        logic        nack;
        logic [15:0] eTemp;
        logic        eAck;
        int          eCyc;
    } vec_t;
    vec_t vecs[5];

    initial begin : stim
        int s0, p0, d0;
        vecs[0] = '{0, 8'h19, 8'h60, 1'b0, 16'h1960, 1'b0, 465};
        vecs[1] = '{0, 8'hAA, 8'h55, 1'b1, 16'h1960, 1'b1, 177};
        vecs[2] = '{1, 8'h19, 8'h60, 1'b0, 16'h1960, 1'b0, 233};
        vecs[3] = '{0, 8'h12, 8'h34, 1'b0, 16'h1234, 1'b0, 465};
        vecs[4] = '{1, 8'hC3, 8'h3C, 1'b1, 16'h1960, 1'b1, 89};

        Reset = 1'b0;
        start = 2'b00;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("reset_bits", int'({scl[i], sdaDrive[i], busy[i], done[i], ackError[i],
                                     writeLoad[i], shiftorHold[i], shiftIn[i]}), 8'h80);
            chk("reset_temperature", int'(temperature[i]), 0);
            chk("reset_sentdata", int'(sentData[i]), 0);
        end
        Reset = 1'b1;
        repeat (3) step();

        for (int v = 0; v < 5; v++)
            runTxn(vecs[v].inst, vecs[v].msb, vecs[v].lsb, vecs[v].nack,
                   vecs[v].eTemp, vecs[v].eAck, vecs[v].eCyc);

        // Start held high, then pulsed again mid-LSB: one transaction only.
        d0 = doneCnt[0];
        slvMsb[0] = 8'h0A; slvLsb[0] = 8'hBC; slvNack[0] = 1'b0;
        sbq.push_back('{0, 16'h0ABC, 1'b0, 465});
        start[0] = 1'b1;
        repeat (100) step();
        start[0] = 1'b0;
        waitRise(0, 21);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        waitDone(0);
        repeat (20) step();
        chk("held_start_done_pulses", doneCnt[0] - d0, 1);
        chk("held_start_queue_empty", sbq.size(), 0);
        chk("held_start_busy_low", int'(busy[0]), 0);

        // Reset during MSB bit 3 must drop the bus at once, with no Done.
        d0 = doneCnt[0];
        launch(0, 8'h19, 8'h60, 1'b0, 1'b0, 16'h0, 1'b0, 0);
        waitRise(0, 13);
        step();
        Reset = 1'b0;
        #1;
        chk("async_reset_scl", int'(scl[0]), 1);
        chk("async_reset_sda", int'(sdaDrive[0]), 0);
        chk("async_reset_busy", int'(busy[0]), 0);
        repeat (3) step();
        chk("async_reset_temperature", int'(temperature[0]), 0);
        Reset = 1'b1;
        repeat (3) step();
        chk("async_reset_no_done", doneCnt[0] - d0, 0);
        runTxn(0, 8'hFF, 8'hF0, 1'b0, 16'hFFF0, 1'b0, 465);

        // Start during the Done cycle is ignored.
        launch(0, 8'h19, 8'h60, 1'b0, 1'b1, 16'h1960, 1'b0, 465);
        waitDone(0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("done_cycle_start_ignored", int'(busy[0]), 0);
        repeat (3) step();

        // Start in the first IDLE cycle after Done is accepted.
        s0 = startCnt[0];
        p0 = stopCnt[0];
        launch(0, 8'h25, 8'h80, 1'b0, 1'b1, 16'h2580, 1'b0, 465);
        waitDone(0);
        step();
        launch(0, 8'h19, 8'h60, 1'b0, 1'b1, 16'h1960, 1'b0, 465);
        chk("back_to_back_accepted", int'(busy[0]), 1);
        waitDone(0);
        repeat (3) step();
        chk("b2b_start_conditions", startCnt[0] - s0, 2);
        chk("b2b_stop_conditions", stopCnt[0] - p0, 2);
        chk("b2b_queue_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected the run to end");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_tmp101_read_controller.md
# i2c_tmp101_read_controller

Sequences one I2C read of the TMP101 temperature register (two bytes) by driving the team's I2C 8-bit shift register (load/shift/hold datapath) and generating SCL/SDA bus timing. It sits between the lab top level (start button or timer) and the pins. It returns a 16-bit raw temperature word and an ACK-error flag. It uses the TMP101 default pointer (temperature register), so no pointer write is issued.

## Interface
Parameters:
- DIV, 125: CLOCK cycles per quarter SCL period (SCL period = 4·DIV); must be ≥ 2.
- ADDR, 7'b1001000: 7-bit slave address; R/W bit is always 1.

Ports:
- CLOCK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle pulse at end of transaction.
- AckError  out  1  set if slave NACKs address; cleared on next accepted Start.
- Temperature  out  16  {MSB byte, LSB byte}; updated only on successful completion.
- SCL  out  1  bus clock (push-pull, idle 1).
- SDA_Drive  out  1  1 = pull SDA low, 0 = release (open-drain enable).
- SDA_In  in  1  sampled SDA pin level.
- WriteLoad  out  1  to shift register: load SentData.
- SentData  out  8  to shift register: {ADDR, 1'b1}.
- ShiftorHold  out  1  to shift register: shift one bit this cycle.
- ShiftIn  out  1  to shift register: serial input (registered copy of SDA_In).
- ShiftOut  in  1  from shift register MSB.
- ReceivedData  in  8  from shift register parallel contents.

## Operation
- Quarter-tick generator: counter 0..DIV-1, tick when it reaches DIV-1; held at 0 in IDLE; cleared on Start acceptance. Phase counter 0..3 advances per tick.
- Bit slot = 4 quarters: Q0, Q1 SCL=0 (SDA changes at Q0 entry); Q2, Q3 SCL=1; SDA_In sampled at Q2 tick.
- States: IDLE → START → ADDR(8 bits) → AACK → MSB(8) → MACK → LSB(8) → NACK → STOP → IDLE.
- IDLE: SCL=1, SDA released. On Start=1: WriteLoad=1 for one cycle, clear AckError, enter START.
- START (4 quarters): Q0–Q1 SDA released, SCL=1; Q2 SDA_Drive=1 (start condition); Q3 SCL=0.
- ADDR: SDA_Drive = ~ShiftOut; at each Q3 tick ShiftorHold=1 for one cycle (next bit to MSB).
- AACK: SDA released; at Q2 sample. SDA_In=1 → AckError=1, go to STOP (skip reads).
- MSB/LSB: SDA released; at each Q2 tick ShiftIn=SDA_In and ShiftorHold=1. At end of MSB (entry to MACK), latch ReceivedData into internal MSB register.
- MACK: SDA_Drive=1. NACK: SDA released.
- STOP (4 quarters): Q0–Q1 SCL=0, SDA_Drive=1; Q2 SCL=1; Q3 SDA released (stop condition). At exit, Temperature={MSB, ReceivedData} if AckError=0. Done pulses and the controller returns to IDLE.
- WriteLoad and ShiftorHold are never both high.

## Timing
- Reset values: SCL=1, SDA_Drive=0, Busy=0, Done=0, AckError=0, Temperature=0, WriteLoad=0, SentData=0, ShiftorHold=0, ShiftIn=0, state IDLE.
- Successful read: 4+27·4+4 = 116 quarters. Done is asserted in the cycle after the 116th tick, i.e. 116·DIV+1 cycles after the Start-sample edge.
- Address NACK: 4+9·4+4 = 44 quarters, so Done at 44·DIV+1.
- Start while Busy or during the Done cycle is ignored. Start in the first IDLE cycle after Done is accepted.
- Reset asserted mid-transaction: all outputs return to reset values immediately, the bus is released, and no Done pulse is produced.
- SDA_In is not resynchronised here; the top level supplies a 2-flop synchronised pin.

## Test plan
- DIV=4; slave model ACKs and returns 0x19, 0x60 → SDA sequence 1,0,0,1,0,0,0,1 on address bits; Temperature=16'h1960, AckError=0, Done at cycle 465 after Start.
- DIV=4; slave NACKs address → AckError=1, Temperature keeps previous 16'h1960, no SCL pulses beyond bit 9, Done at cycle 177.
- Start held high during transaction and pulsed again mid-LSB → single transaction, exactly one Done.
- Reset low during MSB bit 3 → SCL=1, SDA_Drive=0, Busy=0 asynchronously. A following Start completes normally with 0xFF, 0xF0 → 16'hFFF0.
- Start reasserted on the first cycle after Done → second transaction begins. Check START/STOP conditions (SDA edges only while SCL=1) for both transactions.
- DIV=2 minimum → same 0x1960 result; Done at cycle 233.
